sprite_reg_shadow: RTL
======================

Name: sprite_reg_shadow

Overview:
- Avalon-MM slave register bank between the HPS bus and the sprite/score VGA renderer.
- CPU writes land in a pending bank.
- The pending bank is copied to the active bank only at the first vertical-blank line, so the renderer never sees a half-updated frame (no tearing).
- Also provides a frame counter, status readback, and a one-cycle frame tick that software and hardware can use to pace the game loop.

Parameters:
- NUM_REGS, 16, number of sprite/score registers (addresses 0..NUM_REGS-1).
- DATA_W, 8, width of each register.
- VACTIVE, 480, first blanked line; the commit point.
- FCNT_W, 16, frame counter width.

Ports:
- clk  in  1  50 MHz system clock, same clock as the VGA counters.
- reset  in  1  asynchronous, active-high.
- chipselect  in  1  Avalon slave select.
- write  in  1  Avalon write strobe.
- read  in  1  Avalon read strobe.
- address  in  9  Avalon word address.
- writedata  in  32  Avalon write data.
- readdata  out  32  Avalon read data; fixed read latency 1.
- hcount  in  11  horizontal counter from the VGA timing block.
- vcount  in  10  vertical counter from the VGA timing block.
- active_regs  out  NUM_REGS*DATA_W  flattened active bank, to the renderer; reg i is at bits [i*DATA_W +: DATA_W].
- frame_tick  out  1  one-cycle pulse at the commit point.
- commit_pending  out  1  manual commit armed, not yet executed.

Behaviour:
- Reset (async) values:
  - pending and active banks both = SPRITE_REG_RESET from the package: reg0..12 = 100,100,200,150,44,94,244,100,100,104,0,25,41; reg13..15 = 0.
  - auto_commit = 0, armed = 0, frame_count = 0, readdata = 0, frame_tick = 0.
- Address map:
  - 0..NUM_REGS-1: pending reg. Write takes writedata[DATA_W-1:0]. Read returns pending value zero-extended.
  - 0x100 CTRL: write bit0=1 sets armed (bit0=0 has no effect); bit1 sets auto_commit. Read returns {30'b0, auto_commit, armed}.
  - 0x101 STATUS (read-only): {frame_count[FCNT_W-1:0] in [31:16], 14'b0, vblank_now, armed}. vblank_now = (vcount >= VACTIVE).
  - Any other address: writes ignored, reads return 0.
- Writes take effect when chipselect && write, on that clock edge.
- Reads: when chipselect && read, readdata is registered and valid the next cycle. readdata holds its value when not reading.
- Tick detection:
  - tick_cond = (vcount == VACTIVE) && (hcount == 0).
  - frame_tick is a registered version of tick_cond, so it is high for exactly one cycle, one cycle after tick_cond.
  - The commit executes on the same edge at which frame_tick rises.
- Commit, in the tick cycle:
  - If auto_commit or armed (values before this cycle's write): active <= pending, using pending values before any same-cycle write; armed <= 0; frame_count <= frame_count + 1, wrapping at 2^FCNT_W.
  - If neither is set, active is unchanged and frame_count still increments. frame_count counts frames, not commits.
- Simultaneous events in the tick cycle:
  - Write to a pending reg: the new value lands in pending only; the active bank receives the old value; the new value commits next frame.
  - CTRL write setting armed: armed ends the cycle = 1. The clear from the commit loses; the next frame commits again.
  - Read of STATUS: returns pre-update frame_count and armed.
- commit_pending = armed (direct register output).
- active_regs is driven only from the active bank register; no combinational path from writedata.
- Reset mid-frame: all state returns to reset values immediately. The first tick after reset deassertion behaves normally.

Decomposition:
- Package sprite_regs_pkg:
  - constants NUM_SPRITE_REGS, REG_DATA_W, ADDR_CTRL=9'h100, ADDR_STATUS=9'h101;
  - register index enum (DINO_X=0 … SCORE_Y=12);
  - SPRITE_REG_RESET constant array;
  - ctrl_t packed struct {auto_commit, armed}.
- One natural sub-module: vblank_tick_gen (tick_cond detect, registered pulse, frame_count).

Test Plan:
- Reset, then read regs 0, 4, 12, CTRL and STATUS → 100, 44, 41, 0, 0; active_regs[7:0] = 100.
- Write reg0=55 with no arm, run one frame → active_regs[7:0] stays 100; STATUS[31:16] = 1; read reg0 = 55.
- Write CTRL=1, run to tick → commit_pending = 1 before the tick; at the tick active_regs[7:0] = 55 and commit_pending = 0; the following frame makes no further change.
- Write CTRL=2 (auto), write reg2=77 on the exact tick cycle → active reg2 stays 200 this frame and becomes 77 at the next tick.
- Write CTRL=1 on the tick cycle with armed already = 1 → commit occurs and armed remains 1; the next frame commits again.
- Assert reset mid-line with vcount=200 after modifications → outputs return to reset values within the same cycle; read at 0x1FF returns 0; readdata appears exactly one cycle after the read strobe.

Source files
------------

// File: rtl/sprite_reg_shadow_pkg.sv
// Shared constants, register map and reset image for the sprite register shadow bank.
package sprite_regs_pkg;

    localparam int unsigned NUM_SPRITE_REGS = 16;
    localparam int unsigned REG_DATA_W      = 8;
    localparam int unsigned REG_IDX_W       = 4;
    localparam int unsigned ADDR_W          = 9;
    localparam int unsigned BUS_W           = 32;
    localparam int unsigned HCNT_W          = 11;
    localparam int unsigned VCNT_W          = 10;
    localparam int unsigned FRAME_CNT_W     = 16;
    localparam int unsigned VACTIVE_LINES   = 480;

    localparam logic [ADDR_W-1:0] ADDR_CTRL   = 9'h100;
    localparam logic [ADDR_W-1:0] ADDR_STATUS = 9'h101;

    typedef enum logic [REG_IDX_W-1:0] {
        DINO_X    = 4'd0,
        DINO_Y    = 4'd1,
        CACT0_X   = 4'd2,
        CACT0_Y   = 4'd3,
        CACT1_X   = 4'd4,
        CACT1_Y   = 4'd5,
        CACT2_X   = 4'd6,
        CACT2_Y   = 4'd7,
        BIRD_X    = 4'd8,
        BIRD_Y    = 4'd9,
        SCORE_VAL = 4'd10,
        SCORE_X   = 4'd11,
        SCORE_Y   = 4'd12
    } sprite_reg_e;

    localparam logic [REG_DATA_W-1:0] SPRITE_REG_RESET [NUM_SPRITE_REGS] = '{
        8'd100, 8'd100, 8'd200, 8'd150, 8'd44, 8'd94, 8'd244, 8'd100,
        8'd100, 8'd104, 8'd0,   8'd25,  8'd41, 8'd0,  8'd0,   8'd0
    };

    typedef struct packed {
        logic auto_commit;
        logic armed;
    } ctrl_t;

    // Reset value for any register index; indices beyond the image reset to zero.
    function automatic logic [REG_DATA_W-1:0] reg_reset(input int unsigned idx);
        if (idx < NUM_SPRITE_REGS) begin
            return SPRITE_REG_RESET[REG_IDX_W'(idx)];
        end
        return '0;
    endfunction

endpackage

// File: rtl/sprite_reg_shadow_if.sv
// Avalon-MM slave bus between the HPS bridge and the sprite register bank.
interface sprite_reg_shadow_if;
    import sprite_regs_pkg::*;

    logic              chipselect;
    logic              write;
    logic              read;
    logic [ADDR_W-1:0] address;
    logic [BUS_W-1:0]  writedata;
    logic [BUS_W-1:0]  readdata;

    modport master (
        output chipselect, write, read, address, writedata,
        input  readdata
    );

    modport slave (
        input  chipselect, write, read, address, writedata,
        output readdata
    );
endinterface

// File: rtl/sprite_reg_shadow_vblank_tick_gen.sv
// Detects the first blanked line, emits a one-cycle frame tick and counts frames.
module vblank_tick_gen
    import sprite_regs_pkg::*;
#(
    parameter int unsigned VACTIVE = VACTIVE_LINES,
    parameter int unsigned FCNT_W  = FRAME_CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [HCNT_W-1:0] hcount,
    input  logic [VCNT_W-1:0] vcount,
    output logic              tick_c,
    output logic              frame_tick,
    output logic [FCNT_W-1:0] frame_count
);

    // Commit point: first pixel of the first blanked line.
    assign tick_c = (vcount == VCNT_W'(VACTIVE)) && (hcount == '0);

    // Registered tick pulse and free-running frame counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_tick  <= 1'b0;
            frame_count <= '0;
        end else begin
            frame_tick <= tick_c;
            if (tick_c) begin
                frame_count <= frame_count + FCNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/sprite_reg_shadow.sv
// Double-buffered sprite/score register bank: CPU writes pending, vblank commits to active.
module sprite_reg_shadow
    import sprite_regs_pkg::*;
#(
    parameter int unsigned NUM_REGS = NUM_SPRITE_REGS,
    parameter int unsigned DATA_W   = REG_DATA_W,
    parameter int unsigned VACTIVE  = VACTIVE_LINES,
    parameter int unsigned FCNT_W   = FRAME_CNT_W
) (
    input  logic                       clk,
    input  logic                       reset,
    sprite_reg_shadow_if.slave         bus,
    input  logic [HCNT_W-1:0]          hcount,
    input  logic [VCNT_W-1:0]          vcount,
    output logic [NUM_REGS*DATA_W-1:0] active_regs,
    output logic                       frame_tick,
    output logic                       commit_pending
);

    logic [DATA_W-1:0] pending [NUM_REGS];
    ctrl_t             ctrl;
    logic [FCNT_W-1:0] frame_count;
    logic              tick_c;
    logic              wr_en_c;
    logic              rd_en_c;
    logic              vblank_now_c;
    logic              do_commit_c;
    logic [BUS_W-1:0]  rdata_c;
    logic              unused_wdata_c;

    vblank_tick_gen #(
        .VACTIVE (VACTIVE),
        .FCNT_W  (FCNT_W)
    ) u_tick (
        .clk         (clk),
        .reset       (reset),
        .hcount      (hcount),
        .vcount      (vcount),
        .tick_c      (tick_c),
        .frame_tick  (frame_tick),
        .frame_count (frame_count)
    );

    assign wr_en_c        = bus.chipselect && bus.write;
    assign rd_en_c        = bus.chipselect && bus.read;
    assign vblank_now_c   = (vcount >= VCNT_W'(VACTIVE));
    assign do_commit_c    = tick_c && (ctrl.auto_commit || ctrl.armed);
    assign commit_pending = ctrl.armed;
    assign unused_wdata_c = ^bus.writedata[BUS_W-1:DATA_W];

    // Pending bank: CPU writes only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                pending[i] <= DATA_W'(reg_reset(i));
            end
        end else if (wr_en_c) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (bus.address == ADDR_W'(i)) begin
                    pending[i] <= bus.writedata[DATA_W-1:0];
                end
            end
        end
    end

    // Active bank: snapshot of pending (pre-write values) at the commit tick.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                active_regs[i*DATA_W +: DATA_W] <= DATA_W'(reg_reset(i));
            end
        end else if (do_commit_c) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                active_regs[i*DATA_W +: DATA_W] <= pending[i];
            end
        end
    end

    // Control: the tick clears armed, but a same-cycle CTRL write re-arms.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl <= '0;
        end else begin
            if (tick_c) begin
                ctrl.armed <= 1'b0;
            end
            if (wr_en_c && (bus.address == ADDR_CTRL)) begin
                if (bus.writedata[0]) begin
                    ctrl.armed <= 1'b1;
                end
                ctrl.auto_commit <= bus.writedata[1];
            end
        end
    end

    // Read mux over pending regs, CTRL and STATUS; unmapped addresses read zero.
    always_comb begin
        rdata_c = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (bus.address == ADDR_W'(i)) begin
                rdata_c = BUS_W'(pending[i]);
            end
        end
        if (bus.address == ADDR_CTRL) begin
            rdata_c = BUS_W'(ctrl);
        end
        if (bus.address == ADDR_STATUS) begin
            rdata_c = {16'(frame_count), 14'b0, vblank_now_c, ctrl.armed};
        end
    end

    // Read data register: latency one, holds when idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.readdata <= '0;
        end else if (rd_en_c) begin
            bus.readdata <= rdata_c;
        end
    end

endmodule
